// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding, default operand width and the counter width helper.
package serial_arith_pkg;

    // Two-state sequencer: waiting for a request, or shifting bits through
    // the full-adder cell.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width. The counter only has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder cell: sum and carry of three input bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first. Computes A - B as A + ~B + 1
// using a single full-adder cell and a registered carry, so one result takes
// WIDTH shift cycles after the accepting edge. Start/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 most recent sum bits; the newest sum completes the
    // result on the final shift, so a full-width register is not needed.
    logic [WIDTH-2:0] d_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             b_inv;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] next_diff;

    // Subtrahend bit is inverted into the adder; the +1 comes from the
    // carry being preset to 1 on load.
    assign b_inv     = ~b_sr[0];
    assign next_diff = {fa_sum, d_sr};
    assign busy      = (state == ST_SHIFT);

    full_adder u_full_adder (
        .a     (a_sr[0]),
        .b     (b_inv),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sequencer: load operands on start, shift one bit per cycle, publish
    // the result and pulse done on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are reset too, not just the control
            // state, so an aborted operation leaves no stale bits behind.
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            d_sr    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge values of the others and the default
            // below is cleanly overridden by the last-bit branch.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        d_sr    <= '0;
                        carry_q <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    d_sr    <= next_diff[WIDTH-1:1];
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_carry;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff   <= next_diff;
                        borrow <= ~fa_carry;
                        zero   <= (next_diff == '0);
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): table-driven vectors,
// a scoreboard queue of expected results, and hand-written sequences for
// ignored start, back-to-back operation and mid-operation reset.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        int           acc_edge;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    sb_t  sb[$];
    int   done_edges[$];
    logic [W-1:0] held_diff   = '0;
    logic         held_borrow = 1'b0;
    logic         held_zero   = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Count rising edges; read only on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic, independent of the serial datapath.
    function automatic sb_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc_edge);
        sb_t e;
        e.diff     = a - b;
        e.borrow   = (a < b);
        e.zero     = (a == b);
        e.acc_edge = acc_edge;
        return e;
    endfunction

    // Monitor: compare every done against the scoreboard and verify that
    // the result outputs hold while busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_diff   = '0;
            held_borrow = 1'b0;
            held_zero   = 1'b0;
        end else if (done) begin
            done_edges.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("diff",    32'(diff),   32'(e.diff));
                check("borrow",  32'(borrow), 32'(e.borrow));
                check("zero",    32'(zero),   32'(e.zero));
                check("latency", 32'(cyc - e.acc_edge), 32'(W));
                check("busy_in_done_cycle", 32'(busy), 32'd0);
            end
            held_diff   = diff;
            held_borrow = borrow;
            held_zero   = zero;
        end else if (busy) begin
            check("hold_during_shift", {23'd0, diff, borrow, zero},
                  {23'd0, held_diff, held_borrow, held_zero});
        end
    end

    // Present one request for one cycle; optionally expect its result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ed, input logic eb, input logic ez,
                            input bit expect_result);
        @(negedge clk);
        check("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        if (expect_result) sb.push_back('{diff: ed, borrow: eb, zero: ez, acc_edge: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        a_in  = 'x;
        b_in  = 'x;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("timeout_pending_results", 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 8'h7A, b: 8'h7A, diff: 8'h00, borrow: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0, zero: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, zero: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_diff",   32'(diff),   32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        rst_n = 1'b1;

        // Table-driven functional and boundary vectors.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].zero, 1'b1);
            wait_idle();
        end

        // Start asserted during shift 3 must be ignored.
        start_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("ignored_start_no_extra_op", 32'(busy), 32'd0);

        // Start held high: accepted again in each done cycle.
        begin
            int n_acc = 0;
            done_edges.delete();
            start = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if (!busy) begin
                    if (n_acc == 3) begin
                        start = 1'b0;
                        break;
                    end
                    a_in = W'($urandom_range(0, 255));
                    b_in = W'($urandom_range(0, 255));
                    sb.push_back(model(a_in, b_in, cyc + 1));
                    n_acc++;
                end
                @(negedge clk);
            end
            start = 1'b0;
            wait_idle();
            check("b2b_done_count", 32'(done_edges.size()), 32'd3);
            for (int i = 1; i < done_edges.size(); i++)
                check("b2b_done_spacing", 32'(done_edges[i] - done_edges[i-1]), 32'd9);
        end

        // Reset during shift 4 aborts with no done; next op runs normally.
        start_op(8'h20, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_diff",   32'(diff),   32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_zero",   32'(zero),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        start_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
